// File: rtl/bcd_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_code_sequencer
// Description : Walks a 4-bit code 0..LAST over a valid/ready handshake with
//               a programmable idle gap, single-pass or loop, abort support.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_code_sequencer #(
    parameter int LAST = 9,
    parameter int HOLD = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       loop,
    input  logic       abort,
    input  logic       ready,
    output logic [3:0] code,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] passes
);

    localparam int                 c_GAP_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [3:0]         c_LAST  = 4'(LAST);
    localparam logic [c_GAP_W-1:0] c_HOLD  = c_GAP_W'(HOLD);
    localparam logic [c_GAP_W-1:0] c_ONE   = c_GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_loop;
    logic               w_last;

    assign w_last = (code == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_loop  <= 1'b0;
            code    <= 4'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            passes  <= 8'd0;
        end else if (abort) begin
            // Freeze code/passes/gap; abort in IDLE also swallows a start.
            r_state <= S_IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_loop  <= loop;
                        code    <= 4'd0;
                        r_state <= S_EMIT;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (ready) begin
                        if (w_last && passes != 8'hFF) begin
                            passes <= passes + 8'd1;
                        end
                        if (!w_last || r_loop) begin
                            code <= w_last ? 4'd0 : code + 4'd1;
                            if (HOLD > 0) begin
                                r_state <= S_HOLD;
                                valid   <= 1'b0;
                                r_gap   <= c_HOLD;
                            end
                        end else begin
                            r_state <= S_DONE;
                            valid   <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    r_gap <= r_gap - c_ONE;
                    if (r_gap == c_ONE) begin
                        r_state <= S_EMIT;
                        valid   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
